// File: rtl/csa_reduce_fifo_stage.sv
// Carry-save reduction of NPP partial products to a (SUM, CARRY) pair, buffered
// with a sideband tag in a first-word-fall-through FIFO of DEPTH entries.
module csa_reduce_fifo_stage #(
  parameter int W      = 64,
  parameter int NPP    = 5,
  parameter int SIDE_W = 2,
  parameter int DEPTH  = 2
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic [NPP*W-1:0]             PP_RX0,
  input  logic [SIDE_W-1:0]            SIDE_RX0,
  input  logic                         X0X1_EMPTY_SX0,
  output logic                         X0X1_POP_SX1,
  input  logic                         FLUSH_SX1,
  input  logic                         X1X2_POP_SX2,
  output logic [W-1:0]                 SUM_RX1,
  output logic [W-1:0]                 CARRY_RX1,
  output logic [SIDE_W-1:0]            SIDE_RX1,
  output logic                         X1X2_EMPTY_SX1,
  output logic                         X1X2_FULL_SX1,
  output logic [$clog2(DEPTH+1)-1:0]   X1X2_COUNT_SX1
);

  localparam int CW = $clog2(DEPTH + 1);
  localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  logic [W-1:0] sum_c;
  logic [W-1:0] carry_c;

  generate
    if (NPP == 2) begin : g_pass
      assign sum_c   = PP_RX0[0 +: W];
      assign carry_c = PP_RX0[W +: W];
    end else begin : g_csa
      logic [W-1:0] s_st [NPP-2];
      logic [W-1:0] c_st [NPP-2];
      for (genvar k = 0; k < NPP - 2; k++) begin : g_stage
        logic [W-1:0] a;
        logic [W-1:0] b;
        logic [W-1:0] d;
        logic [W-1:0] maj;
        if (k == 0) begin : g_first
          assign a = PP_RX0[0 +: W];
          assign b = PP_RX0[W +: W];
        end else begin : g_next
          assign a = s_st[k-1];
          assign b = c_st[k-1];
        end
        assign d       = PP_RX0[(k+2)*W +: W];
        assign maj     = (a & b) | (a & d) | (b & d);
        assign s_st[k] = a ^ b ^ d;
        // Carry has twice the weight of the sum bit; the MSB carry falls off.
        assign c_st[k] = maj << 1;
      end
      assign sum_c   = s_st[NPP-3];
      assign carry_c = c_st[NPP-3];
    end
  endgenerate

  logic [W-1:0]      mem_sum   [DEPTH];
  logic [W-1:0]      mem_carry [DEPTH];
  logic [SIDE_W-1:0] mem_side  [DEPTH];
  logic [PW-1:0]     rd_ptr;
  logic [PW-1:0]     wr_ptr;
  logic [CW-1:0]     count;
  logic              empty;
  logic              full;
  logic              pop_int;
  logic              push;

  function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
    return (p == PW'(DEPTH - 1)) ? '0 : p + 1'b1;
  endfunction

  assign empty   = (count == '0);
  assign full    = (count == CW'(DEPTH));
  assign pop_int = X1X2_POP_SX2 & ~empty;
  assign push    = ~reset & ~X0X1_EMPTY_SX0 & (~full | pop_int) & ~FLUSH_SX1;

  always_ff @(posedge clk) begin
    if (reset || FLUSH_SX1) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else begin
      if (push)    wr_ptr <= ptr_inc(wr_ptr);
      if (pop_int) rd_ptr <= ptr_inc(rd_ptr);
      case ({push, pop_int})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: count <= count;
      endcase
    end
  end

  // Storage is not reset; the head is only meaningful while not empty.
  always_ff @(posedge clk) begin
    if (push) begin
      mem_sum[wr_ptr]   <= sum_c;
      mem_carry[wr_ptr] <= carry_c;
      mem_side[wr_ptr]  <= SIDE_RX0;
    end
  end

  assign X0X1_POP_SX1   = push;
  assign SUM_RX1        = mem_sum[rd_ptr];
  assign CARRY_RX1      = mem_carry[rd_ptr];
  assign SIDE_RX1       = mem_side[rd_ptr];
  assign X1X2_EMPTY_SX1 = empty;
  assign X1X2_FULL_SX1  = full;
  assign X1X2_COUNT_SX1 = count;

endmodule

// File: tb/tb_csa_reduce_fifo_stage.sv
// Scoreboard bench: two instances (DEPTH 2 and 3) share stimulus; a queue model
// per instance predicts handshake, flags and the head entry each cycle.
module tb_csa_reduce_fifo_stage;

  localparam int W   = 64;
  localparam int NPP = 5;
  localparam int SW  = 2;

  typedef struct {
    logic [W-1:0]  total;
    logic [SW-1:0] side;
    bit            exact;
    logic [W-1:0]  es;
    logic [W-1:0]  ec;
  } exp_t;

  logic             clk = 1'b0;
  logic             rst;
  logic [NPP*W-1:0] pp_bus;
  logic [SW-1:0]    side_in;
  logic             up_empty;
  logic             flush;
  logic             pop_dn;

  logic [W-1:0]  sum_o   [2];
  logic [W-1:0]  carry_o [2];
  logic [SW-1:0] side_o  [2];
  logic          empty_o [2];
  logic          full_o  [2];
  logic          upop_o  [2];
  logic [1:0]    cnt_o   [2];

  exp_t q0[$];
  exp_t q1[$];
  exp_t cur_exp;
  int   checks = 0;
  int   errors = 0;

  always #5 clk = ~clk;

  csa_reduce_fifo_stage #(.W(W), .NPP(NPP), .SIDE_W(SW), .DEPTH(2)) dut0 (
    .clk(clk), .reset(rst), .PP_RX0(pp_bus), .SIDE_RX0(side_in),
    .X0X1_EMPTY_SX0(up_empty), .X0X1_POP_SX1(upop_o[0]), .FLUSH_SX1(flush),
    .X1X2_POP_SX2(pop_dn), .SUM_RX1(sum_o[0]), .CARRY_RX1(carry_o[0]),
    .SIDE_RX1(side_o[0]), .X1X2_EMPTY_SX1(empty_o[0]), .X1X2_FULL_SX1(full_o[0]),
    .X1X2_COUNT_SX1(cnt_o[0]));

  csa_reduce_fifo_stage #(.W(W), .NPP(NPP), .SIDE_W(SW), .DEPTH(3)) dut1 (
    .clk(clk), .reset(rst), .PP_RX0(pp_bus), .SIDE_RX0(side_in),
    .X0X1_EMPTY_SX0(up_empty), .X0X1_POP_SX1(upop_o[1]), .FLUSH_SX1(flush),
    .X1X2_POP_SX2(pop_dn), .SUM_RX1(sum_o[1]), .CARRY_RX1(carry_o[1]),
    .SIDE_RX1(side_o[1]), .X1X2_EMPTY_SX1(empty_o[1]), .X1X2_FULL_SX1(full_o[1]),
    .X1X2_COUNT_SX1(cnt_o[1]));

  function automatic int dep_of(input int i);
    return (i == 0) ? 2 : 3;
  endfunction

  task automatic chk(input string nm, input int i, input logic [W-1:0] got,
                     input logic [W-1:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s dut%0d: got 0x%0h expected 0x%0h", nm, i, got, exp);
    end
  endtask

  // Monitor: compare against the queue model, then advance the model by the
  // edge that follows (inputs are stable from posedge+1 to the next posedge).
  always @(negedge clk) begin
    for (int i = 0; i < 2; i++) begin
      int   n;
      exp_t hd;
      bit   exp_push;
      bit   popped;
      n = (i == 0) ? q0.size() : q1.size();
      chk("count", i, W'(cnt_o[i]), W'(n));
      chk("empty", i, W'(empty_o[i]), W'(n == 0));
      chk("full", i, W'(full_o[i]), W'(n == dep_of(i)));
      exp_push = !rst && !up_empty && (n < dep_of(i) || (pop_dn && n > 0)) && !flush;
      chk("upstream_pop", i, W'(upop_o[i]), W'(exp_push));
      if (n > 0) begin
        hd = (i == 0) ? q0[0] : q1[0];
        chk("head_side", i, W'(side_o[i]), W'(hd.side));
        chk("head_sum_plus_carry", i, sum_o[i] + carry_o[i], hd.total);
        if (hd.exact) begin
          chk("head_sum", i, sum_o[i], hd.es);
          chk("head_carry", i, carry_o[i], hd.ec);
        end
      end
      popped = pop_dn && (n > 0);
      if (rst || flush) begin
        if (i == 0) q0.delete(); else q1.delete();
      end else begin
        if (popped) begin
          if (i == 0) void'(q0.pop_front()); else void'(q1.pop_front());
        end
        if (exp_push) begin
          if (i == 0) q0.push_back(cur_exp); else q1.push_back(cur_exp);
        end
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_in(input logic [W-1:0] p0, input logic [W-1:0] p1,
                        input logic [W-1:0] p2, input logic [W-1:0] p3,
                        input logic [W-1:0] p4, input logic [SW-1:0] sd);
    pp_bus        = {p4, p3, p2, p1, p0};
    side_in       = sd;
    cur_exp.total = p0 + p1 + p2 + p3 + p4;
    cur_exp.side  = sd;
    cur_exp.exact = 1'b0;
    cur_exp.es    = '0;
    cur_exp.ec    = '0;
  endtask

  task automatic set_tag(input int t);
    set_in(W'(t), '0, '0, '0, '0, SW'(t));
  endtask

  function automatic logic [W-1:0] rnd64();
    return {$urandom(), $urandom()};
  endfunction

  initial begin
    rst = 1'b1; up_empty = 1'b0; flush = 1'b0; pop_dn = 1'b0;
    set_in(rnd64(), rnd64(), rnd64(), rnd64(), rnd64(), 2'b11);
    tick();
    chk("reset_pop", 0, W'(upop_o[0]), '0);
    chk("reset_pop", 1, W'(upop_o[1]), '0);
    tick();
    rst = 1'b0; up_empty = 1'b1;
    tick();

    // Basic reduce and the all-ones wrap case, each pushed then popped.
    set_in(64'd1, 64'd2, 64'd3, 64'd4, 64'd5, 2'b10);
    cur_exp.exact = 1'b1; cur_exp.es = 64'd15; cur_exp.ec = 64'd0;
    up_empty = 1'b0; tick();
    up_empty = 1'b1; pop_dn = 1'b1; tick();
    pop_dn = 1'b0;
    set_in('1, '1, '1, '1, '1, 2'b01);
    cur_exp.exact = 1'b1; cur_exp.es = 64'hFFFF_FFFF_FFFF_FFFF;
    cur_exp.ec = 64'hFFFF_FFFF_FFFF_FFFC;
    up_empty = 1'b0; tick();
    up_empty = 1'b1; pop_dn = 1'b1; tick();
    pop_dn = 1'b0;

    // Fill, hold a valid input against full, then push with a simultaneous pop.
    up_empty = 1'b0;
    set_tag(0); tick();
    set_tag(1); tick();
    chk("full_after_two", 0, W'(full_o[0]), 1);
    chk("count_after_two", 0, W'(cnt_o[0]), 2);
    set_tag(2); tick();
    pop_dn = 1'b1; tick();
    up_empty = 1'b1;
    for (int k = 0; k < 4; k++) tick();
    pop_dn = 1'b0;

    // Flush with a valid input and a pop in the same cycle.
    up_empty = 1'b0;
    set_tag(1); tick();
    set_tag(2); tick();
    flush = 1'b1; pop_dn = 1'b1; set_tag(3); tick();
    flush = 1'b0; pop_dn = 1'b0; up_empty = 1'b1;
    chk("flush_count", 0, W'(cnt_o[0]), 0);
    chk("flush_count", 1, W'(cnt_o[1]), 0);
    set_tag(2); up_empty = 1'b0; tick();
    up_empty = 1'b1; pop_dn = 1'b1; tick();

    // Pop on empty, then seven push/pop pairs to walk the pointers round.
    tick(); tick();
    for (int k = 0; k < 7; k++) begin
      pop_dn = 1'b0; up_empty = 1'b0; set_tag(k); tick();
      pop_dn = 1'b1; up_empty = 1'b1; tick();
    end
    pop_dn = 1'b0;

    for (int k = 0; k < 600; k++) begin
      set_in(rnd64(), rnd64(), rnd64(), rnd64(), rnd64(), SW'($urandom));
      up_empty = ($urandom_range(0, 1) == 0);
      pop_dn   = ($urandom_range(0, 2) != 0);
      flush    = ($urandom_range(0, 39) == 0);
      rst      = ($urandom_range(0, 99) == 0);
      tick();
    end
    rst = 1'b0; flush = 1'b0; up_empty = 1'b1; pop_dn = 1'b1;
    for (int k = 0; k < 5; k++) tick();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
